// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder with direct load, auto-incrementing scan with wrap,
// hold/clear controls and out-of-range detection.
// Latency: 1 cycle from sampled en/mode/sel to out/index/wrap/range_err; no input-to-output path.
module decoder_seq #(
  parameter int SEL_W   = 5,
  parameter int NUM_OUT = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] out,
  output logic               active,
  output logic [SEL_W-1:0]   index,
  output logic               wrap,
  output logic               range_err
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  // One extra bit so NUM_OUT == 2^SEL_W is representable for the range compare.
  localparam logic [SEL_W:0]   NUM_OUT_W = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W-1:0] IDX_ONE   = SEL_W'(1);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic             act_q, act_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  // Next-state: pulses default low every edge, index/active hold unless a mode acts on them.
  always_comb begin
    idx_d  = idx_q;
    act_d  = act_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (en) begin
      case (mode_s)
        MODE_DIRECT: begin
          if ({1'b0, sel} < NUM_OUT_W) begin
            idx_d = sel;
            act_d = 1'b1;
          end else begin
            // Keep the old index so idx stays in range; just blank the output.
            act_d = 1'b0;
            err_d = 1'b1;
          end
        end
        MODE_SCAN: begin
          if (!act_q) begin
            idx_d = '0;
            act_d = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
        MODE_HOLD: begin
          idx_d = idx_q;
          act_d = act_q;
        end
        MODE_CLEAR: begin
          idx_d = '0;
          act_d = 1'b0;
        end
        default: begin
          idx_d = idx_q;
          act_d = act_q;
        end
      endcase
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      act_q  <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      act_q  <= act_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  // One-hot decode straight from registers; only bits below NUM_OUT exist.
  always_comb begin
    out = '0;
    if (act_q) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        out[i] = (idx_q == SEL_W'(i));
      end
    end
  end

  assign active    = act_q;
  assign index     = idx_q;
  assign wrap      = wrap_q;
  assign range_err = err_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: three instances (32, 24 and 6 outputs) share one directed stimulus
// stream; a per-instance behavioural model is compared on every falling edge, and literal
// expectations pin the test-plan scenarios.
module tb_decoder_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [4:0] sel;

  logic [31:0] out32;
  logic [23:0] out24;
  logic [5:0]  out6;
  logic [31:0] out_d [3];
  logic        act_d [3];
  logic [4:0]  idx_d [3];
  logic        wrap_d[3];
  logic        err_d [3];

  int errors = 0;
  int checks = 0;

  localparam int NS[3] = '{32, 24, 6};

  always #5 clock = ~clock;

  decoder_seq #(.SEL_W(5), .NUM_OUT(32)) u_d32 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .out(out32), .active(act_d[0]), .index(idx_d[0]), .wrap(wrap_d[0]), .range_err(err_d[0])
  );
  decoder_seq #(.SEL_W(5), .NUM_OUT(24)) u_d24 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .out(out24), .active(act_d[1]), .index(idx_d[1]), .wrap(wrap_d[1]), .range_err(err_d[1])
  );
  decoder_seq #(.SEL_W(5), .NUM_OUT(6)) u_d6 (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .sel(sel),
    .out(out6), .active(act_d[2]), .index(idx_d[2]), .wrap(wrap_d[2]), .range_err(err_d[2])
  );

  assign out_d[0] = out32;
  assign out_d[1] = {8'b0, out24};
  assign out_d[2] = {26'b0, out6};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: position as an integer, modular arithmetic for the scan.
  int m_idx [3] = '{0, 0, 0};
  bit m_act [3] = '{0, 0, 0};
  bit m_wrap[3] = '{0, 0, 0};
  bit m_err [3] = '{0, 0, 0};

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_idx[k] <= 0; m_act[k] <= 0; m_wrap[k] <= 0; m_err[k] <= 0;
      end else begin
        m_wrap[k] <= 0;
        m_err[k]  <= 0;
        if (en) begin
          case (mode)
            2'b00: begin
              if (int'(sel) < NS[k]) begin
                m_idx[k] <= int'(sel); m_act[k] <= 1;
              end else begin
                m_act[k] <= 0; m_err[k] <= 1;
              end
            end
            2'b01: begin
              if (!m_act[k]) begin
                m_idx[k] <= 0; m_act[k] <= 1;
              end else begin
                m_idx[k]  <= (m_idx[k] + 1) % NS[k];
                m_wrap[k] <= ((m_idx[k] + 1) % NS[k]) == 0;
              end
            end
            2'b11: begin
              m_idx[k] <= 0; m_act[k] <= 0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out[n%0d]", NS[k]), out_d[k], m_act[k] ? (32'd1 << m_idx[k]) : 32'd0);
      chk($sformatf("active[n%0d]", NS[k]), {31'b0, act_d[k]}, {31'b0, m_act[k]});
      chk($sformatf("index[n%0d]", NS[k]), {27'b0, idx_d[k]}, 32'(m_idx[k]));
      chk($sformatf("wrap[n%0d]", NS[k]), {31'b0, wrap_d[k]}, {31'b0, m_wrap[k]});
      chk($sformatf("range_err[n%0d]", NS[k]), {31'b0, err_d[k]}, {31'b0, m_err[k]});
    end
  end

  task automatic step(input logic e, input logic [1:0] m, input logic [4:0] s);
    en = e; mode = m; sel = s;
    @(posedge clock);
    #1;
  endtask

  int seq[8] = '{0, 1, 2, 3, 4, 5, 0, 1};

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b10; sel = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_out", out32, 32'h0);
    chk("reset_index", {27'b0, idx_d[0]}, 32'd0);
    chk("reset_active", {31'b0, act_d[0]}, 32'd0);
    reset = 1'b0;

    // First decode.
    step(1, 2'b00, 5'd5);
    chk("first_out", out32, 32'h0000_0020);
    chk("first_active", {31'b0, act_d[0]}, 32'd1);

    // Direct sweep over every select value.
    for (int s = 0; s < 32; s++) begin
      step(1, 2'b00, 5'(s));
      chk("sweep_out", out32, 32'd1 << s);
      chk("sweep_err", {31'b0, err_d[0]}, 32'd0);
    end

    // Range error on the 24-output instance.
    step(1, 2'b00, 5'd23);
    chk("n24_bit23", {8'b0, out24}, 32'h0080_0000);
    step(1, 2'b00, 5'd27);
    chk("n24_err_out", {8'b0, out24}, 32'h0);
    chk("n24_err_active", {31'b0, act_d[1]}, 32'd0);
    chk("n24_err_pulse", {31'b0, err_d[1]}, 32'd1);
    chk("n24_err_index", {27'b0, idx_d[1]}, 32'd23);
    step(0, 2'b00, 5'd27);
    chk("n24_err_drop", {31'b0, err_d[1]}, 32'd0);

    // Scan with wrap on the 6-output instance.
    step(1, 2'b11, 5'd0);
    for (int i = 0; i < 8; i++) begin
      step(1, 2'b01, 5'd0);
      chk("n6_scan_index", {27'b0, idx_d[2]}, 32'(seq[i]));
      chk("n6_scan_wrap", {31'b0, wrap_d[2]}, (i == 6) ? 32'd1 : 32'd0);
    end

    // Enable low and HOLD keep the scan parked at index 3.
    step(1, 2'b01, 5'd0);
    step(1, 2'b01, 5'd0);
    chk("n6_at3", {26'b0, out6}, 32'h08);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'b01, 5'd0);
      chk("n6_en_low", {26'b0, out6}, 32'h08);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 2'b10, 5'd0);
      chk("n6_hold", {26'b0, out6}, 32'h08);
    end
    step(1, 2'b01, 5'd0);
    chk("n6_resume", {27'b0, idx_d[2]}, 32'd4);

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b1;
    #1;
    chk("async_out", {26'b0, out6}, 32'h0);
    chk("async_index", {27'b0, idx_d[2]}, 32'd0);
    chk("async_active", {31'b0, act_d[2]}, 32'd0);
    reset = 1'b0;
    step(1, 2'b01, 5'd0);
    chk("post_reset_index", {27'b0, idx_d[2]}, 32'd0);
    chk("post_reset_active", {31'b0, act_d[2]}, 32'd1);
    chk("post_reset_wrap", {31'b0, wrap_d[2]}, 32'd0);

    // SCAN -> DIRECT -> SCAN continues from the loaded index.
    step(1, 2'b01, 5'd0);
    step(1, 2'b00, 5'd2);
    step(1, 2'b01, 5'd0);
    chk("scan_after_direct", {27'b0, idx_d[2]}, 32'd3);

    step(0, 2'b10, 5'd0);
    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Parametrised registered binary-to-one-hot decoder for the processor datapath.
- Used for register-file write-enable, peripheral select and scan-style enables.
- Generalises fixed-width combinational decode with four behaviours:
  - configurable output count;
  - a registered index;
  - an auto-incrementing scan mode with wrap;
  - out-of-range detection, plus hold and clear controls.

Parameters:
- SEL_W, 5, width of select input and internal index.
- NUM_OUT, 32, number of one-hot outputs. Legal range is 2 ≤ NUM_OUT ≤ 2^SEL_W; non-power-of-two values are legal.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- en  in  1  update enable; when 0, all state holds regardless of mode.
- mode  in  2  operating mode: 00 DIRECT, 01 SCAN, 10 HOLD, 11 CLEAR.
- sel  in  SEL_W  binary index; used in DIRECT only.
- out  out  NUM_OUT  registered one-hot decode; all zeros when inactive.
- active  out  1  1 when out holds exactly one set bit.
- index  out  SEL_W  current registered index (idx_q).
- wrap  out  1  one-cycle pulse: SCAN stepped from NUM_OUT-1 to 0.
- range_err  out  1  one-cycle pulse: DIRECT load with sel ≥ NUM_OUT.

Behaviour:
- State: idx_q[SEL_W-1:0], act_q, wrap_q, err_q.
- Output mapping:
  - out = act_q ? (1 << idx_q) : 0, decoded combinationally from registers.
  - Only bits 0..NUM_OUT-1 exist.
  - index = idx_q, active = act_q, wrap = wrap_q, range_err = err_q.
- Reset (asynchronous, any time, including mid-scan): idx_q=0, act_q=0, wrap_q=0, err_q=0. out is therefore all zeros.
- Latency: exactly 1 cycle from a sampled en/mode/sel to the corresponding out, index, wrap and range_err.
- wrap_q and err_q are set only by the events below. Every other edge (en=0 or any other mode) drives them to 0, so each is a single-cycle pulse.
- Edge with en=0: idx_q and act_q hold; wrap_q←0, err_q←0.
- DIRECT (en=1, mode=00):
  - If sel < NUM_OUT: idx_q←sel, act_q←1.
  - If sel ≥ NUM_OUT: idx_q holds, act_q←0 (out all zeros), err_q←1.
- SCAN (en=1, mode=01):
  - If act_q=0: idx_q←0, act_q←1. The scan starts at output 0 and wrap is not pulsed.
  - If act_q=1 and idx_q=NUM_OUT-1: idx_q←0, wrap_q←1.
  - Otherwise: idx_q←idx_q+1.
  - The comparison uses NUM_OUT, not 2^SEL_W, so non-power-of-two counts wrap correctly.
- HOLD (en=1, mode=10): idx_q and act_q hold.
- CLEAR (en=1, mode=11): idx_q←0, act_q←0.
- Invariants:
  - idx_q < NUM_OUT at all times.
  - popcount(out) ≤ 1 at all times.
  - out never shows X after reset.
- Mode changes take effect on the next edge. The mode sequence SCAN→DIRECT→SCAN continues the scan from the DIRECT-loaded index.
- No combinational path exists from any input to any output.

Test Plan:
- Reset and first decode: assert reset mid-cycle → out=0, index=0, active=0 immediately (before the next edge). Release reset; DIRECT sel=5 → next cycle out=32'h0000_0020, active=1.
- DIRECT sweep: with NUM_OUT=32, load sel=0..31 on consecutive cycles → out = 1<<sel one cycle later; range_err stays 0 throughout.
- Range error: with NUM_OUT=24, SEL_W=5, DIRECT sel=23 → out bit 23 set. Then sel=27 → out=0, active=0, range_err high for exactly 1 cycle, index stays 23.
- Scan with wrap: with NUM_OUT=6, starting from CLEAR, run 8 SCAN cycles → index sequence 0,1,2,3,4,5,0,1. wrap is high only on the cycle index returns to 0 (7th); no pulse on the initial start.
- Enable and hold: mid-scan at index=3, drop en for 3 cycles, then HOLD for 2 cycles → out stays 0x08 throughout. Resume SCAN → index=4.
- Reset mid-operation: during a SCAN at index=4, pulse reset asynchronously → out=0 at once. The next SCAN after reset → index=0, active=1, wrap=0.
